// File: rtl/int_seq_pkg.sv
// Shared types and defaults for the interrupt-entry / RTI sequencer.
package int_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, RD_HI, RD_LO, POP_FL, POP_LO, POP_HI
  } state_t;

  // waiting=0: request outstanding; waiting=1: request accepted, awaiting mem_rvalid
  typedef struct packed {
    state_t state;
    logic   waiting;
  } seq_t;

  localparam logic [31:0] VEC_BASE_DEFAULT     = 32'h0;
  localparam int unsigned FLAG_W_DEFAULT       = 3;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/int_pending_latch.sv
// Interrupt pending flag: set by a request, cleared when entry is taken, repeats coalesce.
module int_pending_latch (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic pending
);

  logic pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pending_q <= 1'b0;
    else if (clear) pending_q <= 1'b0;
    else if (set)   pending_q <= 1'b1;
  end

  // A request can be taken in the same cycle it arrives.
  assign pending = pending_q | set;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt-entry / RTI sequencer: stalls the front end and drives the stack/memory port.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int unsigned FLAG_W       = FLAG_W_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter logic [31:0] VEC_BASE     = VEC_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              interrupt_signal,
  input  logic              rti_decoded,
  input  logic              jump_pending,
  input  logic [31:0]       pc_current,
  input  logic [FLAG_W-1:0] flags_current,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              fetch_stall,
  output logic              flush_decode,
  output logic              mem_push,
  output logic              mem_pop,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              pc_load,
  output logic [31:0]       pc_load_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_load_value,
  output logic              int_ack
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) + 1 : 1;

  seq_t              seq;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pc_q;
  logic [FLAG_W-1:0] fl_q;
  logic [15:0]       hi_q;
  logic              pending;
  logic              take_int;
  logic              drain_done;

  int_pending_latch u_pending (
    .clk     (clk),
    .reset   (reset),
    .set     (interrupt_signal),
    .clear   (take_int),
    .pending (pending)
  );

  // RTI has priority over a pending interrupt; a jump in flight defers entry.
  assign take_int   = (seq.state == IDLE) && !rti_decoded && pending && !jump_pending;
  // DRAIN always lasts at least one cycle, even with DRAIN_CYCLES=0.
  assign drain_done = (32'(cnt) + 32'd1) >= DRAIN_CYCLES;

  assign busy        = (seq.state != IDLE);
  assign fetch_stall = (seq.state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq              <= '{state: IDLE, waiting: 1'b0};
      cnt              <= '0;
      pc_q             <= '0;
      fl_q             <= '0;
      hi_q             <= '0;
      flush_decode     <= 1'b0;
      mem_push         <= 1'b0;
      mem_pop          <= 1'b0;
      mem_read         <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      pc_load          <= 1'b0;
      pc_load_value    <= '0;
      flags_load       <= 1'b0;
      flags_load_value <= '0;
      int_ack          <= 1'b0;
    end else begin
      flush_decode <= 1'b0;
      pc_load      <= 1'b0;
      flags_load   <= 1'b0;
      int_ack      <= 1'b0;
      case (seq.state)
        IDLE: begin
          seq.waiting <= 1'b0;
          if (rti_decoded) begin
            seq.state    <= POP_FL;
            flush_decode <= 1'b1;
            mem_pop      <= 1'b1;
          end else if (take_int) begin
            seq.state    <= DRAIN;
            flush_decode <= 1'b1;
            pc_q         <= pc_current;
            fl_q         <= flags_current;
            cnt          <= '0;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            seq.state <= PUSH_HI;
            mem_push  <= 1'b1;
            mem_wdata <= pc_q[31:16];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PUSH_HI: if (mem_ready) begin
          seq.state <= PUSH_LO;
          mem_wdata <= pc_q[15:0];
        end
        PUSH_LO: if (mem_ready) begin
          seq.state <= PUSH_FL;
          mem_wdata <= 16'(fl_q);
        end
        PUSH_FL: if (mem_ready) begin
          seq.state <= RD_HI;
          mem_push  <= 1'b0;
          mem_wdata <= '0;
          mem_read  <= 1'b1;
          mem_addr  <= VEC_BASE;
        end
        RD_HI, RD_LO, POP_FL, POP_LO, POP_HI: begin
          if (!seq.waiting) begin
            if (mem_ready) begin
              mem_read    <= 1'b0;
              mem_pop     <= 1'b0;
              mem_addr    <= '0;
              seq.waiting <= 1'b1;
            end
          end else if (mem_rvalid) begin
            seq.waiting <= 1'b0;
            case (seq.state)
              RD_HI: begin
                hi_q      <= mem_rdata;
                seq.state <= RD_LO;
                mem_read  <= 1'b1;
                mem_addr  <= VEC_BASE + 32'd1;
              end
              RD_LO: begin
                seq.state     <= IDLE;
                pc_load       <= 1'b1;
                pc_load_value <= {hi_q, mem_rdata};
                int_ack       <= 1'b1;
              end
              POP_FL: begin
                fl_q      <= mem_rdata[FLAG_W-1:0];
                seq.state <= POP_LO;
                mem_pop   <= 1'b1;
              end
              POP_LO: begin
                pc_q[15:0] <= mem_rdata;
                seq.state  <= POP_HI;
                mem_pop    <= 1'b1;
              end
              default: begin
                seq.state        <= IDLE;
                pc_load          <= 1'b1;
                pc_load_value    <= {mem_rdata, pc_q[15:0]};
                flags_load       <= 1'b1;
                flags_load_value <= fl_q;
              end
            endcase
          end
        end
        default: seq <= '{state: IDLE, waiting: 1'b0};
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer with a small stack/vector memory responder.
module tb_int_sequencer;

  localparam int unsigned FW = 3;
  localparam int unsigned DC = 3;
  localparam logic [31:0] VB = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          interrupt_signal = 1'b0;
  logic          rti_decoded = 1'b0;
  logic          jump_pending = 1'b0;
  logic [31:0]   pc_current = '0;
  logic [FW-1:0] flags_current = '0;
  logic          mem_ready = 1'b1;
  logic          mem_rvalid = 1'b1;
  logic [15:0]   mem_rdata;
  logic          busy, fetch_stall, flush_decode, mem_push, mem_pop, mem_read;
  logic [31:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          pc_load;
  logic [31:0]   pc_load_value;
  logic          flags_load;
  logic [FW-1:0] flags_load_value;
  logic          int_ack;

  int checks = 0;
  int errors = 0;

  logic [15:0] push_log [64];
  int          push_n = 0;
  logic [15:0] pop_stack [3];
  int          pop_idx = 0;
  logic [15:0] rdata_q = '0;

  int_sequencer #(.FLAG_W(FW), .DRAIN_CYCLES(DC), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .interrupt_signal(interrupt_signal),
    .rti_decoded(rti_decoded), .jump_pending(jump_pending),
    .pc_current(pc_current), .flags_current(flags_current),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .fetch_stall(fetch_stall), .flush_decode(flush_decode),
    .mem_push(mem_push), .mem_pop(mem_pop), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .flags_load(flags_load),
    .flags_load_value(flags_load_value), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rdata_q;

  // Memory responder: logs accepted pushes, returns vector/stack data the cycle after acceptance.
  always @(posedge clk) begin
    if (mem_push && mem_ready) begin
      push_log[push_n % 64] <= mem_wdata;
      push_n <= push_n + 1;
    end
    if (mem_read && mem_ready)
      rdata_q <= (mem_addr == VB) ? 16'h0000 : (mem_addr == VB + 32'd1) ? 16'h0100 : 16'hDEAD;
    if (mem_pop && mem_ready) begin
      rdata_q <= pop_stack[pop_idx % 3];
      pop_idx <= pop_idx + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pc_load && n < 60);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({busy, fetch_stall, flush_decode, mem_push, mem_pop, mem_read, mem_addr, mem_wdata,
         pc_load, pc_load_value, flags_load, flags_load_value, int_ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b push=%b pop=%b read=%b pc_load=%b required all zero",
               busy, mem_push, mem_pop, mem_read, pc_load);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b stall=%b required 0 0", busy, fetch_stall);
    end
  endtask

  task automatic test_entry();
    int n;
    int start;
    logic excl_ok;
    pc_current = 32'h0001_2345;
    flags_current = 3'b101;
    start = push_n;
    interrupt_signal = 1'b1;
    tick();
    interrupt_signal = 1'b0;
    pc_current = 32'hFFFF_FFFF;
    flags_current = 3'b000;
    checks++;
    if (flush_decode !== 1'b1 || busy !== 1'b1 || fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL entry_start: flush=%b busy=%b stall=%b required 1 1 1", flush_decode, busy, fetch_stall);
    end
    n = 0;
    excl_ok = 1'b1;
    while (!pc_load && n < 60) begin
      tick();
      n++;
      if ($countones({mem_push, mem_pop, mem_read}) > 1) excl_ok = 1'b0;
    end
    checks++;
    if (n !== DC + 7) begin
      errors++;
      $display("FAIL entry_latency: got %0d cycles required %0d", n, DC + 7);
    end
    checks++;
    if (pc_load_value !== 32'h0000_0100 || int_ack !== 1'b1 || flags_load !== 1'b0) begin
      errors++;
      $display("FAIL entry_load: pc=%h ack=%b fl_load=%b required 00000100 1 0", pc_load_value, int_ack, flags_load);
    end
    checks++;
    if (excl_ok !== 1'b1) begin
      errors++;
      $display("FAIL entry_excl: got overlapping requests=%b required 1", excl_ok);
    end
    checks++;
    if (push_n - start !== 3 || push_log[start % 64] !== 16'h0001 ||
        push_log[(start + 1) % 64] !== 16'h2345 || push_log[(start + 2) % 64] !== 16'h0005) begin
      errors++;
      $display("FAIL entry_pushes: n=%0d data=%h %h %h required 3 0001 2345 0005", push_n - start,
               push_log[start % 64], push_log[(start + 1) % 64], push_log[(start + 2) % 64]);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || int_ack !== 1'b0 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL entry_end: busy=%b ack=%b pc_load=%b required 0 0 0", busy, int_ack, pc_load);
    end
  endtask

  task automatic test_rti();
    int n;
    pop_stack[0] = 16'h0005;
    pop_stack[1] = 16'h2345;
    pop_stack[2] = 16'h0001;
    rti_decoded = 1'b1;
    tick();
    rti_decoded = 1'b0;
    checks++;
    if (flush_decode !== 1'b1 || mem_pop !== 1'b1 || busy !== 1'b1 || mem_push !== 1'b0) begin
      errors++;
      $display("FAIL rti_start: flush=%b pop=%b busy=%b push=%b required 1 1 1 0", flush_decode, mem_pop, busy, mem_push);
    end
    wait_load(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL rti_latency: got %0d cycles required 6", n);
    end
    checks++;
    if (pc_load_value !== 32'h0001_2345 || flags_load !== 1'b1 || flags_load_value !== 3'b101 || int_ack !== 1'b0) begin
      errors++;
      $display("FAIL rti_load: pc=%h fl_load=%b flags=%b ack=%b required 00012345 1 101 0",
               pc_load_value, flags_load, flags_load_value, int_ack);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || flags_load !== 1'b0) begin
      errors++;
      $display("FAIL rti_end: busy=%b fl_load=%b required 0 0", busy, flags_load);
    end
  endtask

  task automatic reach_push_lo();
    int n;
    pc_current = 32'h0001_2345;
    flags_current = 3'b101;
    interrupt_signal = 1'b1;
    tick();
    interrupt_signal = 1'b0;
    n = 0;
    while (!(mem_push && mem_wdata == 16'h2345) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    int start;
    reach_push_lo();
    checks++;
    if (mem_push !== 1'b1 || mem_wdata !== 16'h2345) begin
      errors++;
      $display("FAIL bp_reach: push=%b wdata=%h required 1 2345", mem_push, mem_wdata);
    end
    mem_ready = 1'b0;
    start = push_n;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_push !== 1'b1 || mem_wdata !== 16'h2345 || mem_read !== 1'b0 || mem_pop !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: push=%b wdata=%h read=%b required 1 2345 0", i, mem_push, mem_wdata, mem_read);
      end
    end
    checks++;
    if (push_n !== start) begin
      errors++;
      $display("FAIL bp_no_accept: got %0d pushes required 0", push_n - start);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (mem_push !== 1'b1 || mem_wdata !== 16'h0005) begin
      errors++;
      $display("FAIL bp_advance: push=%b wdata=%h required 1 0005", mem_push, mem_wdata);
    end
    wait_load(n);
    checks++;
    if (pc_load !== 1'b1 || pc_load_value !== 32'h0000_0100) begin
      errors++;
      $display("FAIL bp_load: pc_load=%b pc=%h required 1 00000100", pc_load, pc_load_value);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic quiet;
    reach_push_lo();
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, fetch_stall, flush_decode, mem_push, mem_pop, mem_read, mem_addr, mem_wdata,
         pc_load, pc_load_value, flags_load, flags_load_value, int_ack} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b push=%b wdata=%h required all zero", busy, mem_push, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pc_load !== 1'b0 || busy !== 1'b0 || mem_push !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: got activity after reset=%b required none", ~quiet);
    end
  endtask

  task automatic test_collision();
    int n;
    int acks;
    pop_stack[0] = 16'h0002;
    pop_stack[1] = 16'h5678;
    pop_stack[2] = 16'h0003;
    pc_current = 32'h0000_4444;
    flags_current = 3'b011;
    rti_decoded = 1'b1;
    interrupt_signal = 1'b1;
    tick();
    rti_decoded = 1'b0;
    interrupt_signal = 1'b0;
    checks++;
    if (mem_pop !== 1'b1 || mem_push !== 1'b0) begin
      errors++;
      $display("FAIL coll_rti_wins: pop=%b push=%b required 1 0", mem_pop, mem_push);
    end
    tick();
    tick();
    interrupt_signal = 1'b1;
    tick();
    interrupt_signal = 1'b0;
    n = 0;
    while (!pc_load && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (flags_load !== 1'b1 || int_ack !== 1'b0 || pc_load_value !== 32'h0003_5678 || flags_load_value !== 3'b010) begin
      errors++;
      $display("FAIL coll_rti_first: fl_load=%b ack=%b pc=%h flags=%b required 1 0 00035678 010",
               flags_load, int_ack, pc_load_value, flags_load_value);
    end
    tick();
    checks++;
    if (flush_decode !== 1'b1 || busy !== 1'b1 || mem_pop !== 1'b0) begin
      errors++;
      $display("FAIL coll_entry_next: flush=%b busy=%b pop=%b required 1 1 0", flush_decode, busy, mem_pop);
    end
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_single_entry: got %0d acks busy=%b required 1 0", acks, busy);
    end
  endtask

  task automatic test_deferral();
    int n;
    logic held;
    pc_current = 32'h0001_2345;
    flags_current = 3'b101;
    jump_pending = 1'b1;
    interrupt_signal = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      interrupt_signal = 1'b0;
      if (busy !== 1'b0 || flush_decode !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL defer_hold: entered during jump=%b required 0", ~held);
    end
    jump_pending = 1'b0;
    tick();
    checks++;
    if (flush_decode !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL defer_entry: flush=%b busy=%b required 1 1", flush_decode, busy);
    end
    wait_load(n);
    checks++;
    if (n !== DC + 7 || pc_load_value !== 32'h0000_0100 || int_ack !== 1'b1) begin
      errors++;
      $display("FAIL defer_load: cycles=%0d pc=%h ack=%b required %0d 00000100 1", n, pc_load_value, int_ack, DC + 7);
    end
    tick();
  endtask

  initial begin
    pop_stack[0] = '0;
    pop_stack[1] = '0;
    pop_stack[2] = '0;
    test_reset();
    test_entry();
    test_rti();
    test_backpressure();
    test_reset_mid();
    test_collision();
    test_deferral();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
